// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide: one adder, WIDTH iterations, sign fix-up at the end.
// Multiply is shift-add on magnitudes; divide is restoring with the quotient built LSB-in.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_q, op_d, sy_q, sy_d, sb_q, sb_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 dz_q, dz_d, dzp_q, dzp_d;
  logic [WIDTH-1:0]     mc_q, mc_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]       rem_q, rem_d;
  // Multiply: {partial high, remaining multiplier}. Divide: low half is dividend/quotient,
  // or the raw dividend on a divide-by-zero.
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic [WIDTH-1:0]     y_mag, b_mag, quot_fix, rem_fix;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;

  assign y_mag    = Y[WIDTH-1] ? -Y : Y;
  assign b_mag    = B[WIDTH-1] ? -B : B;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mc_q : {WIDTH{1'b0}})};
  assign div_sh   = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mc_q};
  assign prod_fix = (sy_q ^ sb_q) ? -acc_q : acc_q;
  assign quot_fix = (sy_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sy_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sy_d    = sy_q;
    sb_d    = sb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    dzp_d   = dzp_q;
    mc_d    = mc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (start) begin
        op_d  = op;
        sy_d  = Y[WIDTH-1];
        sb_d  = B[WIDTH-1];
        dz_d  = 1'b0;
        rem_d = '0;
        if (op && (B == '0)) begin
          dzp_d   = 1'b1;
          acc_d   = {{WIDTH{1'b0}}, Y};
          state_d = DONE;
        end else begin
          dzp_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          mc_d    = op ? b_mag : y_mag;
          acc_d   = {{WIDTH{1'b0}}, (op ? y_mag : b_mag)};
          state_d = CALC;
        end
      end
      CALC: begin
        if (op_q) begin
          // Restoring step: keep the difference only when it did not go negative.
          if (!div_diff[WIDTH]) begin
            rem_d              = div_diff;
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d              = div_sh;
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        hi_d    = op_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = op_q ? quot_fix : prod_fix[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (dzp_q) begin
          hi_d   = acc_q[WIDTH-1:0];
          lo_d   = '1;
          dz_d   = 1'b1;
          done_d = 1'b1;
          dzp_d  = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      sy_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      dzp_q   <= 1'b0;
      mc_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sy_q    <= sy_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      dzp_q   <= dzp_d;
      mc_q    <= mc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized + directed bench for muldiv_seq against a 64-bit arithmetic reference.
module tb_muldiv_seq;
  logic        clk = 1'b0, clr = 1'b1, start = 1'b0, op = 1'b0;
  logic [31:0] Y = '0, B = '0;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;
  int          n_vec = 0, n_err = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .Y(Y), .B(B),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic in 64 bits (SV division truncates toward zero,
  // remainder follows the dividend).
  function automatic void model(input logic o, input logic [31:0] y, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sy, sb, p, q, r;
    sy = longint'($signed(y));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!o) begin
      p  = sy * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = y;
      lo = '1;
      dz = 1'b1;
    end else begin
      q  = sy / sb;
      r  = sy % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Issue one operation; optionally fire a stray start at edge k+inj (inj=0 disables).
  task automatic run_op(input logic o, input logic [31:0] y, input logic [31:0] b, input int inj);
    logic [31:0] ehi, elo;
    logic        edz;
    int          lat, bcnt, ov;
    model(o, y, b, ehi, elo, edz);
    @(negedge clk);
    op = o; Y = y; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; Y = $urandom; B = $urandom; op = $urandom_range(0, 1);
    lat = 0; bcnt = 0; ov = 0;
    while (1) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (busy && done) ov++;
      if (done || lat >= 100) break;
      if (lat == inj - 1) begin
        start = 1'b1; Y = $urandom; B = $urandom;
      end
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
    end
    chk("latency", 64'(lat), edz ? 64'd1 : 64'd33);
    chk("busy_cycles", 64'(bcnt), edz ? 64'd0 : 64'd33);
    chk("busy_and_done", 64'(ov), 64'd0);
    chk("HI", 64'(HI), 64'(ehi));
    chk("LO", 64'(LO), 64'(elo));
    chk("div_zero", 64'(div_zero), 64'(edz));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("HI_hold", 64'(HI), 64'(ehi));
    chk("dz_hold", 64'(div_zero), 64'(edz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_HI", 64'(HI), 64'd0);
    chk("rst_LO", 64'(LO), 64'd0);

    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 0);
    run_op(1'b0, 32'h80000000, 32'h80000000, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, 0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(1'b1, 32'h1234, 32'd0, 0);
    run_op(1'b0, 32'd5, 32'd6, 0);          // clears div_zero
    run_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 10);

    // Reset at edge k+15 of a divide.
    @(negedge clk);
    op = 1'b1; Y = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_HI", 64'(HI), 64'd0);
    chk("mid_rst_LO", 64'(LO), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (done) chk("mid_rst_stray_done", 64'(done), 64'd0);
    end
    run_op(1'b1, 32'd1000, 32'd3, 0);

    for (int i = 0; i < 50; i++) begin
      logic [31:0] ry, rb;
      ry = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(0, 15)) - 32'd8;
        2: ry = 32'($urandom_range(0, 255)) - 32'd128;
        default: ;
      endcase
      run_op(1'($urandom_range(0, 1)), ry, rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
